// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store unit with req/ack bus, alignment check and ack timeout
//
// Ports:
//   CLK, Reset             clock (rising edge), synchronous active-high reset
//   MemRead, MemWrite      load / store request from EX, sampled only while Busy=0
//   Funct3                 access size: 000 B, 001 H, 010 W, 100 BU, 101 HU (others = W)
//   ALUResult              byte address of the access
//   WriteData              store data, LSBs used for B/H
//   Busy                   high while a bus transaction is open
//   ReadData, ReadValid    last completed load value (extended) and its one-cycle update pulse
//   MisalignErr, BusErr    one-cycle pulses: misaligned request rejected / ack timeout abort
//   mem_req .. mem_be      data-memory bus request side, held stable until ack or abort
//   mem_ack, mem_rdata     data-memory bus completion and read word
module load_store_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic [31:0]       WriteData,
    output logic              Busy,
    output logic [31:0]       ReadData,
    output logic              ReadValid,
    output logic              MisalignErr,
    output logic              BusErr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;
    localparam int         CNT_W  = $clog2(TIMEOUT + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] tcnt;
    logic [2:0]       ld_f3;
    logic [1:0]       ld_off;

    // Size decode uses only Funct3[1:0]; bit 2 selects zero-extension for loads.
    // This maps 011/110/111 onto word accesses.
    logic is_byte, is_half, is_word, misaligned;
    assign is_byte    = (Funct3[1:0] == 2'b00);
    assign is_half    = (Funct3[1:0] == 2'b01);
    assign is_word    = !(is_byte || is_half);
    assign misaligned = (is_half && ALUResult[0]) || (is_word && (ALUResult[1:0] != 2'b00));

    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = WriteData;
        if (is_byte) begin
            store_be    = 4'b0001 << ALUResult[1:0];
            store_wdata = {4{WriteData[7:0]}};
        end else if (is_half) begin
            store_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{WriteData[15:0]}};
        end
    end

    // Bring the addressed lane down to bit 0, then extend per the latched size.
    logic [31:0] shifted;
    logic [31:0] load_val;
    assign shifted = mem_rdata >> {ld_off, 3'b000};
    always_comb begin
        load_val = shifted;
        case (ld_f3[1:0])
            2'b00:   load_val = ld_f3[2] ? {24'b0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = ld_f3[2] ? {16'b0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    assign Busy = (state == ACCESS);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            ld_f3       <= '0;
            ld_off      <= '0;
            ReadData    <= '0;
            ReadValid   <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            ReadValid   <= 1'b0;
            MisalignErr <= 1'b0;
            BusErr      <= 1'b0;
            case (state)
                IDLE: begin
                    // mem_ack seen here is late or spurious and is ignored.
                    if (MemRead || MemWrite) begin
                        if (misaligned) begin
                            MisalignErr <= 1'b1;
                        end else begin
                            // A simultaneous read+write request becomes a store.
                            state     <= ACCESS;
                            tcnt      <= '0;
                            ld_f3     <= Funct3;
                            ld_off    <= ALUResult[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {ALUResult[ADDR_W-1:2], 2'b00};
                            mem_be    <= MemWrite ? store_be : 4'b1111;
                            mem_wdata <= MemWrite ? store_wdata : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                        if (!mem_we) begin
                            ReadData  <= load_val;
                            ReadValid <= 1'b1;
                        end
                    end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
                        // This ack-less cycle brings the count to TIMEOUT: abort.
                        state     <= IDLE;
                        BusErr    <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
